// File: rtl/dwt_column_sequencer.sv
// dwt_column_sequencer
// Column-pass scheduler for the 9/7 DWT. Walks a stored frame row-pair by
// row-pair, adds two symmetric-extension lines at the top and two at the
// bottom, and feeds a {odd, even} stream with sof/eol framing through a
// 2-entry output FIFO. Reads are credit-limited so that no more than two
// beats are ever outstanding between memory and the consumer.
// Optional build macro: DWT_COLSEQ_CHECK_EN validates height/width at start
// and pulses err_o on a rejected start; without it every start is accepted.
module dwt_column_sequencer #(
  parameter int DataWidth       = 16,
  parameter int MaximumSideSize = 32,
  parameter int IdxWidth        = $clog2(MaximumSideSize)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [IdxWidth:0]      height_i,
  input  logic [IdxWidth:0]      width_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   rd_en_o,
  output logic [IdxWidth-1:0]    rd_row_even_o,
  output logic [IdxWidth-1:0]    rd_row_odd_o,
  output logic [IdxWidth-1:0]    rd_col_o,
  input  logic [DataWidth-1:0]   rd_even_data_i,
  input  logic [DataWidth-1:0]   rd_odd_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o
);

  typedef enum logic [2:0] {
    IDLE,
    PREFIX,
    BODY,
    SUFFIX,
    DRAIN
  } state_e;

  typedef struct packed {
    logic                   sof;
    logic                   eol;
    logic [2*DataWidth-1:0] data;
  } beat_t;

  localparam logic [IdxWidth-1:0] IdxOne  = IdxWidth'(1);
  localparam logic [IdxWidth:0]   SizeOne = (IdxWidth+1)'(1);
  localparam logic [IdxWidth:0]   SizeTwo = (IdxWidth+1)'(2);

  state_e              state_q, state_d;
  logic [IdxWidth-1:0] line_q, line_d;
  logic [IdxWidth-1:0] col_q, col_d;
  logic [IdxWidth-1:0] w_last_q, w_last_d;
  logic [IdxWidth-1:0] h_half_last_q, h_half_last_d;
  logic [IdxWidth-1:0] h_m2_q, h_m2_d;
  logic                inflight_q, inflight_d;
  logic                sof_pend_q, sof_pend_d;
  logic                eol_pend_q, eol_pend_d;
  beat_t               head_q, head_d;
  beat_t               tail_q, tail_d;
  logic [1:0]          count_q, count_d;

  logic                active;
  logic                issue;
  logic                pop;
  logic                push;
  logic                last_col;
  logic                last_line;
  logic                drain_done;
  logic                can_start;
  logic                start_ok;
  logic                params_ok;
  logic [2:0]          occupancy;
  logic [IdxWidth-1:0] row_even;
  logic [IdxWidth-1:0] row_odd;
  beat_t               push_beat;

`ifdef DWT_COLSEQ_CHECK_EN
  localparam logic [IdxWidth:0] MaxSide   = (IdxWidth+1)'(MaximumSideSize);
  localparam logic [IdxWidth:0] MinHeight = (IdxWidth+1)'(6);

  logic err_q, err_d;

  // Accept only even heights of at least six rows and non-empty frames that fit
  always_comb begin
    params_ok = !height_i[0] && (height_i >= MinHeight) && (height_i <= MaxSide) &&
                (width_i != '0) && (width_i <= MaxSide);
    err_d     = can_start && start_i && !params_ok;
  end

  // Error pulse register, one cycle after the rejected start
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign params_ok = 1'b1;
  assign err_o     = 1'b0;
`endif

  // Read credit: FIFO entries plus the in-flight read, a pop this cycle frees a slot
  always_comb begin
    active    = (state_q == PREFIX) || (state_q == BODY) || (state_q == SUFFIX);
    pop       = (count_q != 2'd0) && m_ready_i;
    push      = inflight_q;
    occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    issue     = active && (occupancy < (3'd2 + {2'b00, pop}));
    last_col  = (col_q == w_last_q);
    last_line = (state_q == BODY) ? (line_q == h_half_last_q) : (line_q == IdxOne);
  end

  // Row pair addressed by the current line, including the mirrored edge lines
  always_comb begin
    row_even = '0;
    row_odd  = '0;
    unique case (state_q)
      PREFIX: begin
        if (line_q == '0) begin
          row_even = IdxWidth'(4);
          row_odd  = IdxWidth'(3);
        end else begin
          row_even = IdxWidth'(2);
          row_odd  = IdxWidth'(1);
        end
      end
      BODY: begin
        row_even = {line_q[IdxWidth-2:0], 1'b0};
        row_odd  = {line_q[IdxWidth-2:0], 1'b1};
      end
      SUFFIX: begin
        if (line_q == '0) begin
          row_even = h_m2_q;
          row_odd  = h_m2_q - IdxWidth'(1);
        end else begin
          row_even = h_m2_q - IdxWidth'(2);
          row_odd  = h_m2_q - IdxWidth'(3);
        end
      end
      default: begin
      end
    endcase
  end

  // Sequencer next state: line/column walk, state changes and frame start
  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    col_d         = col_q;
    w_last_d      = w_last_q;
    h_half_last_d = h_half_last_q;
    h_m2_d        = h_m2_q;
    inflight_d    = issue;
    sof_pend_d    = sof_pend_q;
    eol_pend_d    = eol_pend_q;

    drain_done = (state_q == DRAIN) && (count_q == 2'd0) && !inflight_q;
    can_start  = (state_q == IDLE) || drain_done;
    start_ok   = can_start && start_i && params_ok;

    if (issue) begin
      sof_pend_d = (state_q == PREFIX) && (line_q == '0) && (col_q == '0);
      eol_pend_d = last_col;
    end

    unique case (state_q)
      PREFIX, BODY, SUFFIX: begin
        if (issue) begin
          if (last_col) begin
            col_d = '0;
            if (last_line) begin
              line_d = '0;
              unique case (state_q)
                PREFIX:  state_d = BODY;
                BODY:    state_d = SUFFIX;
                default: state_d = DRAIN;
              endcase
            end else begin
              line_d = line_q + IdxOne;
            end
          end else begin
            col_d = col_q + IdxOne;
          end
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_d = IDLE;
        end
      end
      default: begin
      end
    endcase

    if (start_ok) begin
      state_d       = PREFIX;
      line_d        = '0;
      col_d         = '0;
      w_last_d      = IdxWidth'(width_i - SizeOne);
      h_half_last_d = IdxWidth'((height_i >> 1) - SizeOne);
      h_m2_d        = IdxWidth'(height_i - SizeTwo);
    end
  end

  // Output FIFO: head register drives the stream, tail holds the second entry
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    push_beat = {sof_pend_q, eol_pend_q, rd_odd_data_i, rd_even_data_i};
    unique case ({push, pop})
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = push_beat;
        end else begin
          head_d = tail_q;
          tail_d = push_beat;
        end
      end
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = push_beat;
        end else begin
          tail_d = push_beat;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      default: begin
      end
    endcase
  end

  // State register; reset drops the frame, the FIFO and any in-flight read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      line_q        <= '0;
      col_q         <= '0;
      w_last_q      <= '0;
      h_half_last_q <= '0;
      h_m2_q        <= '0;
      inflight_q    <= 1'b0;
      sof_pend_q    <= 1'b0;
      eol_pend_q    <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= 2'd0;
    end else begin
      state_q       <= state_d;
      line_q        <= line_d;
      col_q         <= col_d;
      w_last_q      <= w_last_d;
      h_half_last_q <= h_half_last_d;
      h_m2_q        <= h_m2_d;
      inflight_q    <= inflight_d;
      sof_pend_q    <= sof_pend_d;
      eol_pend_q    <= eol_pend_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  assign busy_o        = (state_q != IDLE) && !drain_done;
  assign done_o        = drain_done;
  assign rd_en_o       = issue;
  assign rd_row_even_o = row_even;
  assign rd_row_odd_o  = row_odd;
  assign rd_col_o      = col_q;
  assign m_valid_o     = (count_q != 2'd0);
  assign m_sof_o       = head_q.sof;
  assign m_eol_o       = head_q.eol;
  assign m_data_o      = head_q.data;

endmodule

// File: tb/tb_dwt_column_sequencer.sv
// tb_dwt_column_sequencer
// Self-checking bench for dwt_column_sequencer: a frame-memory model answers
// reads, a scoreboard holds the expected {sof, eol, odd, even} beats built
// from the frame geometry, and a negedge monitor compares accepted beats,
// stall stability, read credits and start/done timing.
module tb_dwt_column_sequencer;

  localparam int DataWidth = 16;
  localparam int MaxSide   = 32;
  localparam int IdxWidth  = 5;

  logic                   clk;
  logic                   rst_i;
  logic                   start_i;
  logic [IdxWidth:0]      height_i;
  logic [IdxWidth:0]      width_i;
  logic                   busy_o;
  logic                   done_o;
  logic                   err_o;
  logic                   rd_en_o;
  logic [IdxWidth-1:0]    rd_row_even_o;
  logic [IdxWidth-1:0]    rd_row_odd_o;
  logic [IdxWidth-1:0]    rd_col_o;
  logic [DataWidth-1:0]   rd_even_data_i;
  logic [DataWidth-1:0]   rd_odd_data_i;
  logic                   m_ready_i;
  logic                   m_valid_o;
  logic                   m_sof_o;
  logic                   m_eol_o;
  logic [2*DataWidth-1:0] m_data_o;

  logic [33:0] exp_q[$];
  logic [33:0] beat_now;
  logic [33:0] prev_beat;
  logic [53:0] out_vec;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int ready_mode = 0;
  int beat_count;
  int first_valid_cyc;
  int first_rd_cyc;
  int last_beat_cyc;
  int done_cyc;
  int start_cyc;
  int outstanding = 0;
  int err_seen = 0;
  logic done_seen;
  logic prev_stall = 1'b0;
  logic expect_err = 1'b0;
  logic xfer;

  dwt_column_sequencer #(
    .DataWidth(DataWidth),
    .MaximumSideSize(MaxSide),
    .IdxWidth(IdxWidth)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .start_i(start_i),
    .height_i(height_i),
    .width_i(width_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o),
    .rd_en_o(rd_en_o),
    .rd_row_even_o(rd_row_even_o),
    .rd_row_odd_o(rd_row_odd_o),
    .rd_col_o(rd_col_o),
    .rd_even_data_i(rd_even_data_i),
    .rd_odd_data_i(rd_odd_data_i),
    .m_ready_i(m_ready_i),
    .m_valid_o(m_valid_o),
    .m_sof_o(m_sof_o),
    .m_eol_o(m_eol_o),
    .m_data_o(m_data_o)
  );

  assign beat_now = {m_sof_o, m_eol_o, m_data_o};
  assign out_vec  = {busy_o, done_o, err_o, rd_en_o, rd_row_even_o, rd_row_odd_o, rd_col_o,
                     m_valid_o, m_sof_o, m_eol_o, m_data_o};

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Frame sample value: row in the high byte, column in the low byte
  function automatic logic [15:0] memVal(input int row, input int col);
    return 16'((row << 8) | col);
  endfunction

  // Frame memory model with one cycle of read latency
  always @(posedge clk) begin
    if (rd_en_o) begin
      rd_even_data_i <= memVal(int'(rd_row_even_o), int'(rd_col_o));
      rd_odd_data_i  <= memVal(int'(rd_row_odd_o), int'(rd_col_o));
    end
  end

  // Downstream ready: always high, or the 1,0,0,1 pattern
  initial begin
    m_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready_i = (ready_mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic buildExpected(input int h, input int w);
    int even_rows[$];
    int odd_rows[$];
    exp_q.delete();
    even_rows.push_back(4); odd_rows.push_back(3);
    even_rows.push_back(2); odd_rows.push_back(1);
    for (int k = 0; k < h / 2; k++) begin
      even_rows.push_back(2 * k);
      odd_rows.push_back(2 * k + 1);
    end
    even_rows.push_back(h - 2); odd_rows.push_back(h - 3);
    even_rows.push_back(h - 4); odd_rows.push_back(h - 5);
    for (int l = 0; l < even_rows.size(); l++) begin
      for (int c = 0; c < w; c++) begin
        exp_q.push_back({(l == 0 && c == 0), (c == w - 1),
                         memVal(odd_rows[l], c), memVal(even_rows[l], c)});
      end
    end
  endtask

  task automatic clearMonitor();
    beat_count      = 0;
    first_valid_cyc = -1;
    first_rd_cyc    = -1;
    last_beat_cyc   = -1;
    done_cyc        = -1;
    done_seen       = 1'b0;
  endtask

  // Monitor: scoreboard compare, stall stability, read credits, done timing
  always @(negedge clk) begin
    if (rst_i) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      xfer = m_valid_o && m_ready_i;
      if (prev_stall) checkOutput("stall_hold", {29'd0, m_valid_o, beat_now}, {29'd0, 1'b1, prev_beat});
      if (m_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (rd_en_o && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (xfer) begin
        if (exp_q.size() == 0) begin
          checkOutput("sb_extra_beat", 64'(beat_now), 64'd0);
        end else begin
          checkOutput("beat", 64'(beat_now), 64'(exp_q.pop_front()));
        end
        beat_count++;
        last_beat_cyc = cyc;
      end
      outstanding = outstanding + int'(rd_en_o) - int'(xfer);
      if (rd_en_o) checkOutput("outstanding_le2", 64'(outstanding <= 2), 64'd1);
      prev_stall = m_valid_o && !m_ready_i;
      prev_beat  = beat_now;
      if (done_o) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        checkOutput("busy_at_done", 64'(busy_o), 64'd0);
      end
      if (err_o && !expect_err) err_seen++;
    end
  end

  // mode 0: ready high; mode 1: ready 1,0,0,1; mode 2: ready high plus a mid-frame start
  task automatic applyStimulus(input int h, input int w, input int mode);
    buildExpected(h, w);
    clearMonitor();
    ready_mode = (mode == 1) ? 1 : 0;
    @(posedge clk);
    #1;
    start_i   = 1'b1;
    height_i  = (IdxWidth+1)'(h);
    width_i   = (IdxWidth+1)'(w);
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    if (mode == 2) begin
      repeat (20) @(posedge clk);
      #1;
      start_i  = 1'b1;
      height_i = (IdxWidth+1)'(6);
      width_i  = (IdxWidth+1)'(1);
      @(posedge clk);
      #1;
      start_i = 1'b0;
    end
    for (int i = 0; i < 3000 && !done_seen; i++) @(negedge clk);
    if (!done_seen) checkOutput("done_timeout", 64'd0, 64'd1);
    checkOutput("beat_count", 64'(beat_count), 64'((h / 2 + 4) * w));
    checkOutput("sb_empty", 64'(exp_q.size()), 64'd0);
    checkOutput("first_rd_lat", 64'(first_rd_cyc - start_cyc), 64'd1);
    checkOutput("first_valid_lat", 64'(first_valid_cyc - start_cyc), 64'd3);
    checkOutput("done_lat", 64'(done_cyc - last_beat_cyc), 64'd1);
    ready_mode = 0;
  endtask

  task automatic applyResetMidFrame();
    buildExpected(16, 16);
    clearMonitor();
    ready_mode = 0;
    @(posedge clk);
    #1;
    start_i  = 1'b1;
    height_i = (IdxWidth+1)'(16);
    width_i  = (IdxWidth+1)'(16);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    for (int i = 0; i < 1000 && beat_count < 50; i++) @(negedge clk);
    checkOutput("reach_beat50", 64'(beat_count >= 50), 64'd1);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_mid_outputs", 64'(out_vec), 64'd0);
    checkOutput("no_done_on_reset", 64'(done_seen), 64'd0);
    rst_i = 1'b0;
    exp_q.delete();
  endtask

`ifdef DWT_COLSEQ_CHECK_EN
  task automatic applyBadStart(input int h, input int w);
    expect_err = 1'b1;
    @(posedge clk);
    #1;
    start_i  = 1'b1;
    height_i = (IdxWidth+1)'(h);
    width_i  = (IdxWidth+1)'(w);
    @(negedge clk);
    checkOutput("bad_busy0", 64'(busy_o), 64'd0);
    checkOutput("bad_rden0", 64'(rd_en_o), 64'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    checkOutput("bad_err", 64'(err_o), 64'd1);
    checkOutput("bad_busy1", 64'(busy_o), 64'd0);
    checkOutput("bad_rden1", 64'(rd_en_o), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("bad_err_pulse", 64'(err_o), 64'd0);
    checkOutput("bad_rden2", 64'(rd_en_o), 64'd0);
    expect_err = 1'b0;
  endtask
`endif

  // Main sequence
  initial begin
    rst_i          = 1'b1;
    start_i        = 1'b0;
    height_i       = '0;
    width_i        = '0;
    rd_even_data_i = '0;
    rd_odd_data_i  = '0;
    clearMonitor();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", 64'(out_vec), 64'd0);
    rst_i = 1'b0;

    $display("[TB] 16x16 frame, ready high");
    applyStimulus(16, 16, 0);
    $display("[TB] 16x16 frame, ready toggling");
    applyStimulus(16, 16, 1);
    $display("[TB] minimum 6x1 frame");
    applyStimulus(6, 1, 0);
    $display("[TB] 16x16 frame with mid-frame start");
    applyStimulus(16, 16, 2);
`ifdef DWT_COLSEQ_CHECK_EN
    $display("[TB] rejected starts");
    applyBadStart(7, 16);
    applyBadStart(4, 16);
    applyBadStart(16, 0);
`endif
    $display("[TB] reset at beat 50, then clean frame");
    applyResetMidFrame();
    applyStimulus(16, 16, 0);

    repeat (3) @(posedge clk);
    checkOutput("err_spurious", 64'(err_seen), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
